// File: rtl/pueo_trig_pkg.sv
// pueo_trig_pkg: shared source ids, queue entry type and metadata layout for the TURF trigger scheduler
package pueo_trig_pkg;
  localparam int NSRC_DEF = 4;
  localparam int SRC_W = $clog2(NSRC_DEF);
  localparam int META_VALID_BIT = 7;
  typedef enum logic [SRC_W-1:0] {
    SRC_RF   = 0,
    SRC_SOFT = 1,
    SRC_PPS  = 2,
    SRC_EXT  = 3
  } src_t;
  typedef struct packed {
    logic [11:0] addr;
    logic [SRC_W-1:0] src;
  } trig_entry_t;
endpackage

// File: rtl/pueo_trig_fifo.sv
// pueo_trig_fifo: first-word-fall-through trigger queue with synchronous flush
module pueo_trig_fifo #(
  parameter int AW = 3,
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  entry_t mem [2**AW];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt[AW];
  assign empty = cnt == '0;
  assign rdata = mem[rp];
  // storage array, written only when there is room
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  // pointers and occupancy; flush discards everything at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/pueo_trig_sched.sv
// pueo_trig_sched: arbitrates trigger sources, applies holdoff, queues accepts and replays them one per frame
module pueo_trig_sched
  import pueo_trig_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int FIFO_AWIDTH = 3,
  parameter int DROPW = 16
) (
  input  logic                    sysclk_i,
  input  logic                    sysclk_rstb_i,
  input  logic                    sysclk_phase_i,
  input  logic                    running_i,
  input  logic [11:0]             cur_addr_i,
  input  logic [NSRC-1:0]         src_req_i,
  input  logic [NSRC-1:0]         src_mask_i,
  input  logic [15:0]             holdoff_i,
  output logic [11:0]             turf_trig_o,
  output logic [7:0]              turf_metadata_o,
  output logic [$clog2(NSRC)-1:0] turf_src_o,
  output logic                    turf_valid_o,
  output logic                    accept_o,
  output logic [DROPW-1:0]        dropped_cnt_o,
  output logic [DROPW-1:0]        overflow_cnt_o
);
  localparam int SW = $clog2(NSRC);
  logic [NSRC-1:0] eff;
  logic [SW-1:0] idx;
  logic [15:0] hold_cnt;
  logic [1:0] phs, wcnt;
  logic [6:0] seq;
  logic hold_act, win, run_q, rise, fall, full, empty, pop, wlast;
  logic [DROPW:0] drop_sum, ovf_sum;
  int n_drop;
  trig_entry_t head, wentry;
  assign eff = src_req_i & ~src_mask_i & {NSRC{running_i}};
  assign hold_act = hold_cnt != 16'd0;
  assign win = |eff && !hold_act;
  assign rise = running_i && !run_q;
  assign fall = run_q && !running_i;
  assign wlast = turf_valid_o && wcnt == 2'd3;
  // a new window may start on the last cycle of the previous one, never inside it
  assign pop = phs[1] && !empty && !fall && (!turf_valid_o || wlast);
  assign wentry = '{addr: cur_addr_i, src: idx};
  assign drop_sum = (rise ? '0 : {1'b0, dropped_cnt_o}) + (DROPW+1)'(n_drop);
  assign ovf_sum = (rise ? '0 : {1'b0, overflow_cnt_o}) + (DROPW+1)'(win && full);
  // lowest set index wins; losers, or everyone during holdoff, are counted as dropped
  always_comb begin
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) idx = eff[i] ? i[SW-1:0] : idx;
    n_drop = hold_act ? $countones(eff) : (|eff ? $countones(eff) - 1 : 0);
  end
  // metadata carries a fixed marker bit above the sequence number
  always_comb begin
    turf_metadata_o = {1'b0, seq};
    turf_metadata_o[META_VALID_BIT] = 1'b1;
  end
  pueo_trig_fifo #(.AW(FIFO_AWIDTH), .entry_t(trig_entry_t)) u_fifo (
    .clk(sysclk_i),
    .rst_n(sysclk_rstb_i),
    .flush(fall),
    .push(win),
    .pop(pop),
    .wdata(wentry),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  // holdoff, frame timing, 4-cycle output window, sequence number and saturating counters
  always_ff @(posedge sysclk_i or negedge sysclk_rstb_i)
    if (!sysclk_rstb_i) begin
      run_q <= 1'b0;
      phs <= '0;
      hold_cnt <= '0;
      accept_o <= 1'b0;
      dropped_cnt_o <= '0;
      overflow_cnt_o <= '0;
      seq <= '0;
      turf_trig_o <= '0;
      turf_src_o <= '0;
      turf_valid_o <= 1'b0;
      wcnt <= '0;
    end else begin
      run_q <= running_i;
      phs <= {phs[0], sysclk_phase_i};
      accept_o <= win;
      hold_cnt <= fall ? '0 : win ? holdoff_i : hold_act ? hold_cnt - 16'd1 : hold_cnt;
      dropped_cnt_o <= drop_sum[DROPW] ? '1 : drop_sum[DROPW-1:0];
      overflow_cnt_o <= ovf_sum[DROPW] ? '1 : ovf_sum[DROPW-1:0];
      seq <= rise ? '0 : wlast ? seq + 7'd1 : seq;
      turf_trig_o <= pop ? head.addr : turf_trig_o;
      turf_src_o <= pop ? head.src : turf_src_o;
      turf_valid_o <= pop || (turf_valid_o && !wlast);
      wcnt <= pop ? '0 : turf_valid_o ? wcnt + 2'd1 : wcnt;
    end
endmodule

// File: tb/tb_pueo_trig_sched.sv
// tb_pueo_trig_sched: directed, table-driven and random checks against a cycle-level reference model
module tb_pueo_trig_sched;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic phase = 1'b0;
  logic running = 1'b0;
  logic [11:0] addr = '0;
  logic [3:0] req = '0;
  logic [3:0] mask = '0;
  logic [15:0] holdoff = '0;
  logic [11:0] trig;
  logic [7:0] meta;
  logic [1:0] src;
  logic valid, acc;
  logic [15:0] dcnt, ocnt;

  pueo_trig_sched dut (
    .sysclk_i(clk),
    .sysclk_rstb_i(rstb),
    .sysclk_phase_i(phase),
    .running_i(running),
    .cur_addr_i(addr),
    .src_req_i(req),
    .src_mask_i(mask),
    .holdoff_i(holdoff),
    .turf_trig_o(trig),
    .turf_metadata_o(meta),
    .turf_src_o(src),
    .turf_valid_o(valid),
    .accept_o(acc),
    .dropped_cnt_o(dcnt),
    .overflow_cnt_o(ocnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [11:0] addr; logic [1:0] src;} ent_t;
  typedef struct {logic [3:0] req; logic [3:0] mask; bit acc; int dd; int src;} vec_t;

  int n_tests = 0;
  int n_fail = 0;
  bit mcheck = 1;

  // reference model: a queue of entries, a holdoff deadline and window timing by cycle number
  int cyc = 0;
  ent_t mq[$];
  bit ph_at[int];
  int m_blk, m_drop, m_ovf, m_lpop, m_seq;
  bit m_acc, m_prun;
  logic [11:0] m_trig;
  logic [1:0] m_src;
  bit m_valid;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ph_at.delete();
    m_blk = -1; m_drop = 0; m_ovf = 0; m_lpop = -100; m_seq = 0;
    m_acc = 0; m_prun = 0; m_trig = '0; m_src = '0; m_valid = 0;
    cyc++;
  endtask

  task automatic model_step();
    logic [3:0] eff;
    int n, w, sz;
    bit rise_m, fall_m, wend;
    ent_t e;
    eff = req & ~mask & {4{running}};
    n = $countones(eff);
    sz = mq.size();
    rise_m = running && !m_prun;
    fall_m = m_prun && !running;
    wend = cyc == m_lpop + 4;
    if (phase) ph_at[cyc] = 1;
    if (rise_m) begin m_drop = 0; m_ovf = 0; end
    if (ph_at.exists(cyc - 2) && sz > 0 && !fall_m && cyc - m_lpop >= 4) begin
      e = mq.pop_front();
      m_trig = e.addr; m_src = e.src; m_lpop = cyc;
    end
    m_acc = 0;
    if (n > 0 && cyc <= m_blk) m_drop += n;
    else if (n > 0) begin
      w = 0;
      while (!eff[w]) w++;
      m_drop += n - 1; m_acc = 1; m_blk = cyc + int'(holdoff);
      if (sz >= 8) m_ovf++;
      else mq.push_back('{addr, 2'(w)});
    end
    if (m_drop > 65535) m_drop = 65535;
    if (m_ovf > 65535) m_ovf = 65535;
    m_seq = rise_m ? 0 : wend ? (m_seq + 1) % 128 : m_seq;
    if (fall_m) begin mq.delete(); m_blk = cyc; end
    m_valid = (cyc - m_lpop) >= 0 && (cyc - m_lpop) <= 3;
    m_prun = running;
    cyc++;
  endtask

  task automatic cmp_model();
    if (!mcheck) return;
    chk("model_trig", int'(trig), int'(m_trig));
    chk("model_meta", int'(meta), 128 + m_seq);
    chk("model_src", int'(src), int'(m_src));
    chk("model_valid", int'(valid), int'(m_valid));
    chk("model_accept", int'(acc), int'(m_acc));
    chk("model_dropped", int'(dcnt), m_drop);
    chk("model_overflow", int'(ocnt), m_ovf);
  endtask

  task automatic tick();
    if (rstb) model_step(); else model_reset();
    @(posedge clk);
    #1;
    req = '0;
    phase = 1'b0;
    addr = 12'($urandom);
    cmp_model();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame();
    phase = 1'b1;
    run(3);
  endtask

  task automatic rerun();
    running = 1'b0;
    tick();
    running = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_trig"}, int'(trig), 0);
    chk({tag, "_meta"}, int'(meta), 'h80);
    chk({tag, "_src"}, int'(src), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_accept"}, int'(acc), 0);
    chk({tag, "_dropped"}, int'(dcnt), 0);
    chk({tag, "_overflow"}, int'(ocnt), 0);
  endtask

  initial begin
    vec_t vt[8];
    logic [11:0] a[10];
    int ed;
    vt[0] = '{4'b0101, 4'b0000, 1, 1, 0};
    vt[1] = '{4'b0101, 4'b0001, 1, 0, 2};
    vt[2] = '{4'b1111, 4'b0000, 1, 3, 0};
    vt[3] = '{4'b1000, 4'b0000, 1, 0, 3};
    vt[4] = '{4'b1100, 4'b0100, 1, 0, 3};
    vt[5] = '{4'b0011, 4'b0011, 0, 0, 0};
    vt[6] = '{4'b0110, 4'b1001, 1, 1, 1};
    vt[7] = '{4'b1010, 4'b0010, 1, 0, 3};
    ed = 0;
    run(3);
    chk_reset_vals("reset");
    rstb = 1'b1;
    running = 1'b1;
    run(2);
    // single soft trigger through one frame
    req = 4'b0010;
    a[0] = addr;
    tick();
    chk("t1_accept", int'(acc), 1);
    run(5);
    frame();
    chk("t1_valid", int'(valid), 1);
    chk("t1_trig", int'(trig), int'(a[0]));
    chk("t1_src", int'(src), 1);
    chk("t1_meta", int'(meta), 'h80);
    run(3);
    chk("t1_valid_last", int'(valid), 1);
    tick();
    chk("t1_valid_off", int'(valid), 0);
    chk("t1_meta_next", int'(meta), 'h81);
    // arbitration and masking table
    for (int k = 0; k < 8; k++) begin
      req = vt[k].req;
      mask = vt[k].mask;
      tick();
      ed += vt[k].dd;
      chk($sformatf("tab%0d_accept", k), int'(acc), int'(vt[k].acc));
      chk($sformatf("tab%0d_dropped", k), int'(dcnt), ed);
      mask = '0;
      frame();
      chk($sformatf("tab%0d_valid", k), int'(valid), int'(vt[k].acc));
      if (vt[k].acc) chk($sformatf("tab%0d_src", k), int'(src), vt[k].src);
      run(4);
    end
    // holdoff of 5, sampled at accept time
    holdoff = 16'd5;
    req = 4'b0010;
    tick();
    holdoff = 16'd0;
    run(4);
    req = 4'b0010;
    tick();
    chk("t3_blocked_accept", int'(acc), 0);
    chk("t3_blocked_dropped", int'(dcnt), ed + 1);
    req = 4'b0010;
    tick();
    chk("t3_free_accept", int'(acc), 1);
    repeat (2) begin frame(); run(5); end
    // overflow and in-order replay
    rerun();
    for (int k = 0; k < 10; k++) begin
      req = 4'(1 << (k % 4));
      a[k] = addr;
      tick();
      chk($sformatf("t4_accept%0d", k), int'(acc), 1);
    end
    chk("t4_overflow", int'(ocnt), 2);
    for (int k = 0; k < 8; k++) begin
      frame();
      chk($sformatf("t4_valid%0d", k), int'(valid), 1);
      chk($sformatf("t4_trig%0d", k), int'(trig), int'(a[k]));
      chk($sformatf("t4_src%0d", k), int'(src), k % 4);
      chk($sformatf("t4_meta%0d", k), int'(meta), 'h80 + k);
      run(5);
    end
    frame();
    chk("t4_empty_valid", int'(valid), 0);
    chk("t4_empty_meta", int'(meta), 'h88);
    run(4);
    // sequence number wrap
    rerun();
    for (int k = 0; k < 128; k++) begin
      req = 4'b0001;
      tick();
      frame();
      run(4);
      if (k == 126) chk("wrap_meta_127", int'(meta), 'hFF);
    end
    chk("wrap_meta_0", int'(meta), 'h80);
    // dropped counter saturation under a long holdoff
    rerun();
    holdoff = 16'hFFFF;
    req = 4'b0001;
    tick();
    mcheck = 0;
    for (int k = 0; k < 16400; k++) begin
      req = 4'hF;
      tick();
    end
    mcheck = 1;
    req = 4'hF;
    tick();
    chk("sat_dropped", int'(dcnt), 'hFFFF);
    chk("sat_accept", int'(acc), 0);
    holdoff = 16'd0;
    // running falls mid-window with entries queued
    rerun();
    for (int k = 0; k < 4; k++) begin req = 4'(1 << k); tick(); end
    frame();
    running = 1'b0;
    tick();
    chk("t5_window_kept", int'(valid), 1);
    run(2);
    chk("t5_window_last", int'(valid), 1);
    tick();
    chk("t5_window_end", int'(valid), 0);
    chk("t5_meta_before", int'(meta), 'h81);
    repeat (2) begin
      frame();
      chk("t5_no_valid", int'(valid), 0);
      run(5);
    end
    running = 1'b1;
    tick();
    chk("t5_meta_rerun", int'(meta), 'h80);
    chk("t5_dropped_rerun", int'(dcnt), 0);
    frame();
    chk("t5_flushed", int'(valid), 0);
    run(4);
    // phase pulse inside a window does not truncate it
    req = 4'b0001;
    tick();
    req = 4'b0100;
    a[1] = addr;
    tick();
    frame();
    tick();
    phase = 1'b1;
    run(2);
    chk("mid_valid_kept", int'(valid), 1);
    tick();
    chk("mid_next_valid", int'(valid), 1);
    chk("mid_next_trig", int'(trig), int'(a[1]));
    run(4);
    // asynchronous reset in the middle of a window
    req = 4'b0001;
    tick();
    req = 4'b0010;
    tick();
    frame();
    #3 rstb = 1'b0;
    #1 chk_reset_vals("async");
    run(2);
    rstb = 1'b1;
    frame();
    chk("async_queue_empty", int'(valid), 0);
    run(5);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 49) == 0) mask = 4'($urandom & $urandom);
      if ($urandom_range(0, 19) == 0) holdoff = 16'($urandom_range(0, 6));
      phase = (i % 8 == 0) || ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 199) == 0) running = !running;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
